// File: rtl/pirdsp_c2x1_pkg.sv
// Shared constants for the C2x1 accumulator: mode encodings, packed-product field
// positions, lane-width relation and the accumulator FSM state type.
package pirdsp_c2x1_pkg;

    localparam logic [1:0] MODE_FULL = 2'b10;
    localparam logic [1:0] MODE_HALF = 2'b01;

    localparam int C_W        = 12;
    localparam int LANE_W     = 6;
    localparam int LANE1_LSB  = 6;
    localparam int LANE0_LSB  = 0;

    // A full accumulator is exactly two half-mode lanes laid side by side.
    localparam int LANE_RATIO = 2;
    localparam int FULL_W_DEF = 24;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } acc_state_e;

    function automatic logic mode_legal(input logic [1:0] mode);
        return (mode == MODE_FULL) || (mode == MODE_HALF);
    endfunction

endpackage

// File: rtl/pirdsp_acc_lane.sv
// One accumulator lane: extends a product to the lane width (sign or zero),
// adds it to the running sum and flags signed overflow or unsigned carry-out.
module pirdsp_acc_lane #(
    parameter int IN_W  = 6,
    parameter int ACC_W = 12
) (
    input  logic [ACC_W-1:0] acc_in,
    input  logic [IN_W-1:0]  prod,
    input  logic             prod_signed,
    input  logic             en,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    logic [ACC_W-1:0] ext;
    logic [ACC_W:0]   wide;

    // A disabled lane adds zero, which can never overflow in either signedness.
    always_comb begin
        ext = '0;
        if (en) begin
            ext = prod_signed ? ACC_W'($signed(prod)) : ACC_W'(prod);
        end
        wide = {1'b0, acc_in} + {1'b0, ext};
        sum  = wide[ACC_W-1:0];
        if (prod_signed) begin
            ovf = (acc_in[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc_in[ACC_W-1]);
        end else begin
            ovf = wide[ACC_W];
        end
    end

endmodule

// File: rtl/pirdsp_c2x1_accumulator.sv
// Accumulates packed 8x4 / dual 4x2 multiplier products over a block and hands
// each block result out through a single valid/ready output register.
module pirdsp_c2x1_accumulator
    import pirdsp_c2x1_pkg::*;
#(
    parameter int ACC_LEN = 16,
    parameter int FULL_W  = FULL_W_DEF,
    parameter int HALF_W  = FULL_W / LANE_RATIO
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [C_W-1:0]    C,
    input  logic              A_sign,
    input  logic              B_sign,
    input  logic              HALF_0,
    input  logic              HALF_1,
    input  logic              in_last,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FULL_W-1:0] out_acc,
    output logic              out_half,
    output logic [1:0]        out_ovf,
    output logic              out_mode_err
);

    localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);

    acc_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FULL_W-1:0] acc_q, acc_d;
    logic [1:0]        mode_q, mode_d;
    logic [1:0]        ovf_q, ovf_d;
    logic              err_q, err_d;
    logic [FULL_W-1:0] out_acc_q, out_acc_d;
    logic              out_half_q, out_half_d;
    logic [1:0]        out_ovf_q, out_ovf_d;
    logic              out_err_q, out_err_d;

    logic [1:0]        beat_mode, eff_mode, beat_ovf;
    logic              legal, first_beat, beat_err, eff_half, prod_signed;
    logic              accept, block_end;
    logic [FULL_W-1:0] full_sum, next_acc;
    logic [HALF_W-1:0] lane1_sum, lane0_sum;
    logic              full_ovf, lane1_ovf, lane0_ovf;

    assign out_valid = (state_q == ST_HOLD);
    assign in_ready  = ~clear & (~out_valid | out_ready);

    // The first beat of a block fixes its mode; an illegal first mode falls back to full.
    always_comb begin
        beat_mode   = {HALF_0, HALF_1};
        legal       = mode_legal(beat_mode);
        first_beat  = (cnt_q == '0);
        prod_signed = A_sign | B_sign;
        eff_mode    = mode_q;
        if (first_beat) begin
            eff_mode = legal ? beat_mode : MODE_FULL;
        end
        eff_half  = (eff_mode == MODE_HALF);
        beat_err  = ~legal | (~first_beat & (beat_mode != mode_q));
        accept    = in_valid & in_ready;
        block_end = accept & (in_last | (cnt_q == LAST_CNT));
    end

    pirdsp_acc_lane #(.IN_W(C_W), .ACC_W(FULL_W)) u_full (
        .acc_in      (acc_q),
        .prod        (C),
        .prod_signed (prod_signed),
        .en          (legal & ~eff_half),
        .sum         (full_sum),
        .ovf         (full_ovf)
    );

    pirdsp_acc_lane #(.IN_W(LANE_W), .ACC_W(HALF_W)) u_lane1 (
        .acc_in      (acc_q[FULL_W-1:HALF_W]),
        .prod        (C[LANE1_LSB +: LANE_W]),
        .prod_signed (prod_signed),
        .en          (legal & eff_half),
        .sum         (lane1_sum),
        .ovf         (lane1_ovf)
    );

    pirdsp_acc_lane #(.IN_W(LANE_W), .ACC_W(HALF_W)) u_lane0 (
        .acc_in      (acc_q[HALF_W-1:0]),
        .prod        (C[LANE0_LSB +: LANE_W]),
        .prod_signed (prod_signed),
        .en          (legal & eff_half),
        .sum         (lane0_sum),
        .ovf         (lane0_ovf)
    );

    always_comb begin
        next_acc = eff_half ? {lane1_sum, lane0_sum} : full_sum;
        beat_ovf = eff_half ? {lane1_ovf, lane0_ovf} : {1'b0, full_ovf};
    end

    // Datapath next state; clear never coincides with an accepted beat.
    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mode_d     = mode_q;
        ovf_d      = ovf_q;
        err_d      = err_q;
        out_acc_d  = out_acc_q;
        out_half_d = out_half_q;
        out_ovf_d  = out_ovf_q;
        out_err_d  = out_err_q;
        if (clear) begin
            cnt_d  = '0;
            acc_d  = '0;
            mode_d = '0;
            ovf_d  = '0;
            err_d  = 1'b0;
        end else if (block_end) begin
            out_acc_d  = next_acc;
            out_half_d = eff_half;
            out_ovf_d  = ovf_q | beat_ovf;
            out_err_d  = err_q | beat_err;
            cnt_d      = '0;
            acc_d      = '0;
            mode_d     = '0;
            ovf_d      = '0;
            err_d      = 1'b0;
        end else if (accept) begin
            cnt_d  = cnt_q + 1'b1;
            acc_d  = next_acc;
            mode_d = eff_mode;
            ovf_d  = ovf_q | beat_ovf;
            err_d  = err_q | beat_err;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: if (block_end) state_d = ST_HOLD;
            ST_HOLD: begin
                if (block_end) begin
                    state_d = ST_HOLD;
                end else if (out_ready) begin
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ACCUM;
            cnt_q      <= '0;
            acc_q      <= '0;
            mode_q     <= '0;
            ovf_q      <= '0;
            err_q      <= 1'b0;
            out_acc_q  <= '0;
            out_half_q <= 1'b0;
            out_ovf_q  <= '0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mode_q     <= mode_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
            out_acc_q  <= out_acc_d;
            out_half_q <= out_half_d;
            out_ovf_q  <= out_ovf_d;
            out_err_q  <= out_err_d;
        end
    end

    assign out_acc      = out_acc_q;
    assign out_half     = out_half_q;
    assign out_ovf      = out_ovf_q;
    assign out_mode_err = out_err_q;

endmodule

// File: tb/tb_pirdsp_c2x1_accumulator.sv
// Directed bench for the C2x1 accumulator: a default-width DUT plus a narrow
// (14/7-bit) DUT that makes lane overflow reachable, both checked against a block-level model.
module tb_pirdsp_c2x1_accumulator;

    localparam int ACC_LEN = 16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [11:0] C;
    logic        A_sign, B_sign, HALF_0, HALF_1, in_last, clear, out_ready;

    logic        in_ready, out_valid, out_half, out_mode_err;
    logic [23:0] out_acc;
    logic [1:0]  out_ovf;

    logic        in_ready_s, out_valid_s, out_half_s, out_mode_err_s;
    logic [13:0] out_acc_s;
    logic [1:0]  out_ovf_s;

    int n_checks = 0;
    int n_fails  = 0;
    int last_wait;

    pirdsp_c2x1_accumulator #(.ACC_LEN(ACC_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .C(C),
        .A_sign(A_sign), .B_sign(B_sign), .HALF_0(HALF_0), .HALF_1(HALF_1),
        .in_last(in_last), .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_half(out_half), .out_ovf(out_ovf), .out_mode_err(out_mode_err)
    );

    pirdsp_c2x1_accumulator #(.ACC_LEN(ACC_LEN), .FULL_W(14), .HALF_W(7)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .C(C),
        .A_sign(A_sign), .B_sign(B_sign), .HALF_0(HALF_0), .HALF_1(HALF_1),
        .in_last(in_last), .clear(clear), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_acc(out_acc_s), .out_half(out_half_s), .out_ovf(out_ovf_s), .out_mode_err(out_mode_err_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block-level model state, index 0 = 24-bit DUT, index 1 = 14-bit DUT.
    longint     m_full[2], m_l1[2], m_l0[2], m_oacc[2];
    int         m_cnt[2];
    logic [1:0] m_mode[2], m_ovf[2], m_oovf[2];
    logic       m_err[2], m_ov[2], m_ohalf[2], m_oerr[2];

    function automatic int full_w(input int k);
        return (k == 0) ? 24 : 14;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic lane_add(inout longint acc, input longint val, input int bits,
                            input int w, input bit sgn, output bit ovf);
        longint m, half_m, e, as_v, s;
        m      = longint'(1) << w;
        half_m = m / 2;
        e      = val;
        if (sgn && val[bits-1]) e = val - (longint'(1) << bits);
        if (sgn) begin
            as_v = (acc >= half_m) ? acc - m : acc;
            s    = as_v + e;
            ovf  = (s < -half_m) || (s > half_m - 1);
        end else begin
            ovf = (acc + e) >= m;
        end
        acc = (((acc + e) % m) + m) % m;
    endtask

    task automatic model_zero_block(input int k);
        m_full[k] = 0; m_l1[k] = 0; m_l0[k] = 0;
        m_cnt[k] = 0; m_mode[k] = 2'b10; m_ovf[k] = 2'b00; m_err[k] = 1'b0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            model_zero_block(k);
            m_ov[k] = 1'b0; m_oacc[k] = 0; m_ohalf[k] = 1'b0; m_oovf[k] = 2'b00; m_oerr[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        bit rdy, take, first, legal, half, sgn, o1, o0, err;
        logic [1:0] md, bm;
        int fw, hw;
        fw   = full_w(k);
        hw   = fw / 2;
        rdy  = !clear && (!m_ov[k] || out_ready);
        take = in_valid && rdy;
        md   = {HALF_0, HALF_1};
        if (clear) model_zero_block(k);
        if (take) begin
            first = (m_cnt[k] == 0);
            legal = (md == 2'b10) || (md == 2'b01);
            bm    = first ? (legal ? md : 2'b10) : m_mode[k];
            err   = !legal || (!first && md != m_mode[k]);
            half  = (bm == 2'b01);
            sgn   = A_sign || B_sign;
            o1 = 1'b0; o0 = 1'b0;
            if (legal) begin
                if (half) begin
                    lane_add(m_l1[k], longint'(C[11:6]), 6, hw, sgn, o1);
                    lane_add(m_l0[k], longint'(C[5:0]), 6, hw, sgn, o0);
                end else begin
                    lane_add(m_full[k], longint'(C), 12, fw, sgn, o0);
                end
            end
            m_ovf[k]  = m_ovf[k] | {o1, o0};
            m_err[k]  = m_err[k] | err;
            m_mode[k] = bm;
            if (in_last || m_cnt[k] == ACC_LEN - 1) begin
                m_oacc[k]  = half ? ((m_l1[k] << hw) | m_l0[k]) : m_full[k];
                m_ohalf[k] = half;
                m_oovf[k]  = m_ovf[k];
                m_oerr[k]  = m_err[k];
                m_ov[k]    = 1'b1;
                model_zero_block(k);
            end else begin
                m_cnt[k]++;
                if (out_ready) m_ov[k] = 1'b0;
            end
        end else if (out_ready) begin
            m_ov[k] = 1'b0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
    end

    // Compare process: DUT outputs against the model every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready, !clear && (!m_ov[0] || out_ready));
            chk("out_valid", out_valid, m_ov[0]);
            if (m_ov[0]) begin
                chk("out_acc", out_acc, m_oacc[0]);
                chk("out_half", out_half, m_ohalf[0]);
                chk("out_ovf", out_ovf, m_oovf[0]);
                chk("out_mode_err", out_mode_err, m_oerr[0]);
            end
            chk("in_ready_s", in_ready_s, !clear && (!m_ov[1] || out_ready));
            chk("out_valid_s", out_valid_s, m_ov[1]);
            if (m_ov[1]) begin
                chk("out_acc_s", out_acc_s, m_oacc[1]);
                chk("out_half_s", out_half_s, m_ohalf[1]);
                chk("out_ovf_s", out_ovf_s, m_oovf[1]);
                chk("out_mode_err_s", out_mode_err_s, m_oerr[1]);
            end
        end
    end

    // Presents one beat (called #1 after a rising edge) and returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [11:0] c, input logic as, input logic bs,
                                 input logic h0, input logic h1, input logic last);
        bit ok;
        in_valid = 1'b1; C = c; A_sign = as; B_sign = bs;
        HALF_0 = h0; HALF_1 = h1; in_last = last;
        ok = 1'b0;
        last_wait = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            last_wait++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL beat_accept_timeout: got in_ready=0 for 50 cycles, expected acceptance");
        end
    endtask

    task automatic checkOutput(input string name, input logic [23:0] exp_acc, input logic exp_half,
                               input logic [1:0] exp_ovf, input logic exp_err);
        chk({name, "_valid"}, out_valid, 1'b1);
        chk({name, "_acc"}, out_acc, exp_acc);
        chk({name, "_half"}, out_half, exp_half);
        chk({name, "_ovf"}, out_ovf, exp_ovf);
        chk({name, "_err"}, out_mode_err, exp_err);
    endtask

    task automatic check_zero_outputs(input string name);
        chk({name, "_valid"}, out_valid, 1'b0);
        chk({name, "_acc"}, out_acc, 24'h0);
        chk({name, "_half"}, out_half, 1'b0);
        chk({name, "_ovf"}, out_ovf, 2'b00);
        chk({name, "_err"}, out_mode_err, 1'b0);
        chk({name, "_in_ready"}, in_ready, 1'b1);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        model_reset();
        rst_n = 1'b0; in_valid = 1'b0; C = '0; A_sign = 1'b0; B_sign = 1'b0;
        HALF_0 = 1'b1; HALF_1 = 1'b0; in_last = 1'b0; clear = 1'b0; out_ready = 1'b1;
        repeat (2) idle_cycle();
        check_zero_outputs("reset");
        rst_n = 1'b1;
        idle_cycle();

        $display("[TB] full unsigned block");
        for (int i = 0; i < 4; i++) applyStimulus(12'd100, 0, 0, 1, 0, i == 3);
        checkOutput("full_unsigned", 24'd400, 0, 2'b00, 0);

        $display("[TB] full signed block");
        applyStimulus(12'hF9C, 1, 0, 1, 0, 0);
        applyStimulus(12'hF9C, 1, 0, 1, 0, 0);
        applyStimulus(12'd50, 1, 0, 1, 0, 1);
        checkOutput("full_signed", 24'hFFFF6A, 0, 2'b00, 0);

        $display("[TB] half signed block");
        for (int i = 0; i < 3; i++) applyStimulus({6'h3E, 6'h05}, 0, 1, 0, 1, i == 2);
        checkOutput("half_signed", 24'hFFA00F, 1, 2'b00, 0);

        $display("[TB] auto-dump after ACC_LEN beats");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(12'd1, 0, 0, 1, 0, 0);
            if (i == 15) checkOutput("auto_dump", 24'd16, 0, 2'b00, 0);
        end
        applyStimulus(12'd0, 0, 0, 1, 0, 1);
        checkOutput("auto_rest", 24'd4, 0, 2'b00, 0);
        idle_cycle();

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(12'd7, 0, 0, 1, 0, 0);
        applyStimulus(12'd8, 0, 0, 1, 0, 1);
        checkOutput("bp_first", 24'd15, 0, 2'b00, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_hold_acc", out_acc, 24'd15);
        end
        idle_cycle();
        out_ready = 1'b1;
        applyStimulus(12'd9, 0, 0, 1, 0, 1);
        chk("bp_same_cycle", last_wait, 1);
        checkOutput("bp_reload", 24'd9, 0, 2'b00, 0);

        $display("[TB] mode change mid-block");
        applyStimulus(12'd1, 0, 0, 1, 0, 0);
        applyStimulus(12'd2, 0, 0, 0, 1, 1);
        checkOutput("mode_change", 24'd3, 0, 2'b00, 1);

        $display("[TB] illegal first mode");
        applyStimulus(12'd5, 0, 0, 0, 0, 0);
        applyStimulus(12'd7, 0, 0, 1, 0, 1);
        checkOutput("illegal_mode", 24'd7, 0, 2'b00, 1);

        $display("[TB] clear mid-block");
        applyStimulus(12'd9, 0, 0, 1, 0, 0);
        applyStimulus(12'd9, 0, 0, 1, 0, 0);
        clear = 1'b1; in_valid = 1'b1; C = 12'd100;
        idle_cycle();
        clear = 1'b0; in_valid = 1'b0;
        applyStimulus(12'd3, 0, 0, 1, 0, 1);
        checkOutput("after_clear", 24'd3, 0, 2'b00, 0);

        $display("[TB] overflow-prone blocks");
        for (int i = 0; i < 5; i++) applyStimulus(12'hFFF, 0, 0, 1, 0, i == 4);
        checkOutput("full_big", 24'h004FFB, 0, 2'b00, 0);
        for (int i = 0; i < 3; i++) applyStimulus({6'h3F, 6'h3F}, 0, 0, 0, 1, i == 2);
        checkOutput("half_unsigned", 24'h0BD0BD, 1, 2'b00, 0);
        for (int i = 0; i < 3; i++) applyStimulus({6'h20, 6'h20}, 1, 1, 0, 1, i == 2);
        checkOutput("half_neg", 24'hFA0FA0, 1, 2'b00, 0);
        chk("small_ovf_lit", out_ovf_s, 2'b11);
        chk("small_acc_lit", out_acc_s, 14'h1020);

        $display("[TB] reset with held result and mid-block");
        idle_cycle();
        out_ready = 1'b0;
        applyStimulus(12'd11, 0, 0, 1, 0, 1);
        checkOutput("pre_reset", 24'd11, 0, 2'b00, 0);
        rst_n = 1'b0;
        idle_cycle();
        check_zero_outputs("reset_held");
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle_cycle();
        applyStimulus(12'd6, 0, 0, 1, 0, 0);
        applyStimulus(12'd6, 0, 0, 1, 0, 0);
        rst_n = 1'b0;
        idle_cycle();
        check_zero_outputs("reset_mid");
        rst_n = 1'b1;
        idle_cycle();
        applyStimulus(12'd4, 0, 0, 1, 0, 1);
        checkOutput("post_reset", 24'd4, 0, 2'b00, 0);
        repeat (3) idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pirdsp_c2x1_accumulator.md
# pirdsp_c2x1_accumulator

Downstream accumulation stage for the 8x4 / dual 4x2 fractured multiplier. It takes the 12-bit packed product word `C` with the same sign and HALF mode controls that drove the multiplier and unpacks it into one 24-bit lane (full mode) or two 12-bit lanes (half mode). Each lane is sign- or zero-extended and accumulated over a block of products. At the end of each block it presents the result through a valid/ready output register.

## Interface
- `ACC_LEN`, 16: products per block before an automatic dump (2..65535)
- `FULL_W`, 24: full-mode accumulator width
- `HALF_W`, 12: width of each half-mode lane accumulator (2*HALF_W == FULL_W)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  product beat valid
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`
- `C`  in  12  packed product from the multiplier
- `A_sign`, `B_sign`  in  1 each  operand signedness used for this product
- `HALF_0`, `HALF_1`  in  1 each  mode: 10 = full 8x4, 01 = dual 4x2
- `in_last`  in  1  forces this beat to close the block
- `clear`  in  1  synchronous abort of the partial block
- `out_valid`  out  1  result held
- `out_ready`  in  1  result consumed when `out_valid & out_ready`
- `out_acc`  out  24  full: lane sum; half: {lane1, lane0}
- `out_half`  out  1  result was produced in half mode
- `out_ovf`  out  2  sticky per-lane overflow (full mode uses bit 0 only)
- `out_mode_err`  out  1  illegal or inconsistent mode within the block

## Operation
- Product signedness: `prod_signed = A_sign | B_sign`.
- Full mode: the product `C[11:0]` is extended to `FULL_W` bits.
- Half mode:
  - lane1 = `C[11:6]`, lane0 = `C[5:0]`.
  - Each lane is extended to `HALF_W` bits and accumulated independently.
  - No carry crosses between lanes.
- Extension is a sign extension when `prod_signed` is set, otherwise a zero extension.
- Block mode:
  - Latched from HALF_0/HALF_1 on the first beat of a block (beat count 0).
  - All later beats in the block are interpreted in the latched mode.
  - A later beat whose mode differs from the latched mode sets `mode_err`.
- Illegal mode (00 or 11):
  - On the first beat, the latched mode defaults to full.
  - The beat contributes zero and sets `mode_err`.
- Overflow:
  - Signed lanes flag two's-complement overflow of the lane add.
  - Unsigned lanes flag carry-out of the lane add.
  - The flag is sticky for the block.
- Block end: an accepted beat with `in_last=1` or with `beat_cnt == ACC_LEN-1`. On that beat:
  - The output register loads accumulator + this product, plus the block's flags.
  - The accumulator, count and flags go to zero.
- Output register: a single stage. `in_ready = ~clear & (~out_valid | out_ready)`.
- `clear`:
  - Zeroes the accumulator, count, latched mode and flags.
  - Any beat presented in the same cycle is not accepted.
  - A held output is unaffected.
- State machine: two states, ACCUM and HOLD.
  - HOLD is entered when a block end loads the output register.
  - HOLD returns to ACCUM when `out_ready` is high and no new block end occurs.
  - HOLD stays in HOLD when `out_ready` is high and a simultaneous block end reloads the register.

## Timing
- Reset values: `out_valid=0`, `out_acc=0`, `out_half=0`, `out_ovf=0`, `out_mode_err=0`, `in_ready=1`. The accumulator and count are also 0.
- Reset mid-block discards the partial sum and any held output.
- Latency: a result appears on `out_valid` the cycle after the accepted block-end beat.
- Throughput: one beat per cycle while `out_ready` stays high, including back-to-back single-beat blocks.
- `out_valid`/`out_acc` stay stable until consumed.
- `in_ready` is combinational in `out_ready` and `clear` only, never in `in_valid`.
- `beat_cnt` wraps to 0 at every block end, and never exceeds `ACC_LEN-1`.

## Structure
- A shared package holds:
  - the mode encoding constants (MODE_FULL=2'b10, MODE_HALF=2'b01);
  - the `C` field slice positions (6/6 split);
  - the lane-width relation `FULL_W == 2*HALF_W`.
- One sub-module, `pirdsp_acc_lane`:
  - Performs the width-parameterised extend + add + overflow detection with signed/unsigned select.
  - Instantiated three times: full, lane1 and lane0.

## Test plan
- Full unsigned: `C=12'd100` for 4 beats, `in_last` on the 4th -> `out_acc=24'd400`, `out_half=0`, `out_ovf=0`, `out_valid` one cycle later.
- Full signed: `C=12'hF9C` (-100) twice, then `12'd50` with `in_last` -> `out_acc=24'hFFFF6A` (-150).
- Half signed: `C={6'h3E, 6'h05}` for 3 beats, `in_last` -> lane1=-6, lane0=15, `out_acc=24'hFFA00F`, `out_half=1`.
- Auto-dump (`ACC_LEN=16`):
  - Stimulus: 20 beats of `C=1`, unsigned full, no `in_last`, `out_ready=1`.
  - Response: one result of 16 after beat 16; the 4 remaining beats stay in the accumulator.
- Backpressure:
  - Stimulus: `out_ready=0` after the first result.
  - Response: `in_ready=0`, and the result stays stable for 5 cycles. On `out_ready=1`, the next block-end beat is accepted in the same cycle and reloads the register with no gap.
- Error and abort cases:
  - A mode change from 10 to 01 mid-block -> `out_mode_err=1`.
  - `clear` mid-block -> the next result excludes the pre-clear beats.
  - `rst_n` low mid-block -> all outputs read zero and `out_valid=0`.
